conv_cfg_shadow_regfile: RTL and testbench
==========================================

# conv_cfg_shadow_regfile

Parametrised, double-buffered runtime-parameter register file for the generic convolution core. Host-side writes land in a shadow bank; a commit handshake copies the whole shadow bank into the active bank only when the core is idle, then optionally issues a start pulse. The core consumes the flattened active bank, so its parameters never change mid-computation. Shadow and active banks are both readable.

## Interface
Parameters:
- CFG_WORD_N, 16, number of configuration words (1..256)
- DATA_WIDTH, 32, bits per word (multiple of 8)
- ADDR_WIDTH, 4, word address width; 2^ADDR_WIDTH >= CFG_WORD_N

Ports:
- clk  in  1  clock; everything samples on posedge
- rst_n  in  1  async active-low reset
- wr_en  in  1  write request, one cycle per write
- wr_addr  in  ADDR_WIDTH  word address
- wr_data  in  DATA_WIDTH  write data
- wr_strb  in  DATA_WIDTH/8  byte enables
- wr_err  out  1  registered pulse: write rejected
- rd_en  in  1  read request
- rd_addr  in  ADDR_WIDTH  word address
- rd_sel  in  1  0 = shadow bank, 1 = active bank
- rd_data  out  DATA_WIDTH  read data, registered
- rd_vld  out  1  registered pulse, rd_data valid
- commit_req  in  1  request shadow->active copy
- commit_start  in  1  qualifier of commit_req: issue cal_start after the copy
- core_busy  in  1  core computing; copy is held off while high
- cfg_locked  out  1  commit in progress (state != IDLE)
- cfg_dirty  out  1  shadow modified since the last copy
- commit_done  out  1  registered pulse, active bank just updated
- cal_start  out  1  one-cycle start pulse to the core
- cfg_active  out  CFG_WORD_N*DATA_WIDTH  active bank, word i at bits [i*DATA_WIDTH +: DATA_WIDTH]

## Operation
- FSM states: IDLE, WAIT, COPY, START.
  - IDLE -> WAIT on commit_req; start_flag <= commit_start.
  - WAIT -> COPY on the first edge with core_busy = 0.
  - COPY lasts one cycle. On its exit edge: active <= shadow, cfg_dirty <= 0, commit_done <= 1. Next state is START if start_flag is set, else IDLE.
  - START lasts one cycle (cal_start = 1, Moore output), then -> IDLE.
- commit_req outside IDLE: ignored, except that commit_start = 1 sets start_flag.
- core_busy rising during COPY does not abort the copy.
- A write is accepted when wr_en = 1, state = IDLE and wr_addr < CFG_WORD_N.
  - Enabled bytes update the shadow word; disabled bytes are kept.
  - cfg_dirty <= 1, even when all wr_strb bits are 0.
- A write is rejected when wr_en = 1 and either the state is not IDLE or wr_addr >= CFG_WORD_N. The shadow bank is unchanged and wr_err = 1 next cycle.
- A write and commit_req in the same IDLE cycle: the write is accepted, and the later copy includes it.
- Reads:
  - Always allowed, in every state.
  - rd_data is captured from the bank selected by rd_sel.
  - Out-of-range address returns 0 with rd_vld still asserted.
  - A read in the same cycle as a write to the same word returns the old value.
  - An active-bank read on the COPY exit edge returns the pre-copy value.
- Only accepted writes and the copy change register contents.

## Timing
- Reset values: all shadow and active words = 0, state = IDLE, start_flag = 0. All outputs are 0, including rd_data and cfg_active.
- Reset asserted mid-operation aborts any commit immediately; the next state after release is IDLE.
- Write: shadow is updated on the edge that samples wr_en; wr_err follows one cycle later.
- Read latency is 1 cycle: request in cycle n gives rd_vld/rd_data in cycle n+1. Back-to-back reads give one result per cycle.
- Commit with core_busy = 0, commit_req high in cycle 0:
  - cycle 1: WAIT
  - cycle 2: COPY
  - cycle 3: cfg_active updated, commit_done = 1, and cal_start = 1 if requested
  - cycle 4: IDLE
- Each cycle core_busy stays high in WAIT adds one cycle of latency.
- cfg_locked is high in cycles 1..3 (3 only when START is entered) and low when the state is IDLE.
- cfg_active changes only on the COPY exit edge.

## Test plan
- Reset, then write word 3 = 0xDEADBEEF with strb 0xF, then a second write with strb 0x3 and data 0x00001234 -> shadow[3] reads 0xDEAD1234, active[3] reads 0, cfg_dirty = 1.
- Commit with commit_start = 1 and core_busy = 0 -> commit_done and cal_start are both high in cycle 3; cfg_active word 3 = 0xDEAD1234; cfg_dirty = 0.
- Hold core_busy high for 10 cycles after commit_req; attempt a write during WAIT -> wr_err pulses, shadow unchanged, cfg_active unchanged until core_busy falls; commit_done comes 2 cycles after the fall.
- Write to address CFG_WORD_N, then read address CFG_WORD_N -> wr_err = 1, no state change; rd_data = 0 with rd_vld = 1.
- Write and commit_req in the same IDLE cycle, with commit_start = 0 -> the copy includes the new value, commit_done = 1, cal_start stays 0.
- Drop rst_n while in WAIT -> all outputs 0 asynchronously; after release cfg_locked = 0 and cal_start never fires.

Source files
------------

// File: rtl/conv_cfg_shadow_regfile.sv
// Double-buffered runtime-parameter register file for the convolution core.
// Host writes go to a shadow bank; an idle-gated commit copies it to the active bank.
module conv_cfg_shadow_regfile #(
    parameter int CFG_WORD_N = 16,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wr_en,
    input  logic [ADDR_WIDTH-1:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic [DATA_WIDTH/8-1:0]          wr_strb,
    output logic                             wr_err,
    input  logic                             rd_en,
    input  logic [ADDR_WIDTH-1:0]            rd_addr,
    input  logic                             rd_sel,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             rd_vld,
    input  logic                             commit_req,
    input  logic                             commit_start,
    input  logic                             core_busy,
    output logic                             cfg_locked,
    output logic                             cfg_dirty,
    output logic                             commit_done,
    output logic                             cal_start,
    output logic [CFG_WORD_N*DATA_WIDTH-1:0] cfg_active
);

    localparam int NB = DATA_WIDTH / 8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_COPY  = 2'd2;
    localparam logic [1:0] S_START = 2'd3;

    logic [1:0]            state_q, state_d;
    logic                  start_flag_q, start_flag_d;
    logic [DATA_WIDTH-1:0] shadow_q [CFG_WORD_N];
    logic [DATA_WIDTH-1:0] shadow_d [CFG_WORD_N];
    logic [DATA_WIDTH-1:0] active_q [CFG_WORD_N];
    logic                  dirty_q, dirty_d;
    logic                  wr_err_q, wr_err_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_vld_q;

    logic wr_in_range;
    logic rd_in_range;
    logic wr_ok;
    logic copy_now;

    assign wr_in_range = (int'(wr_addr) < CFG_WORD_N);
    assign rd_in_range = (int'(rd_addr) < CFG_WORD_N);
    assign wr_ok       = wr_en && (state_q == S_IDLE) && wr_in_range;
    assign copy_now    = (state_q == S_COPY);

    always_comb begin
        state_d      = state_q;
        start_flag_d = start_flag_q;
        unique case (state_q)
            S_IDLE: begin
                if (commit_req) begin
                    state_d      = S_WAIT;
                    start_flag_d = commit_start;
                end
            end
            S_WAIT: begin
                if (!core_busy) state_d = S_COPY;
                if (commit_req && commit_start) start_flag_d = 1'b1;
            end
            S_COPY: begin
                state_d = start_flag_q ? S_START : S_IDLE;
                if (commit_req && commit_start) start_flag_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                if (commit_req && commit_start) start_flag_d = 1'b1;
            end
        endcase
    end

    // Byte-masked merge into the addressed shadow word.
    always_comb begin
        shadow_d = shadow_q;
        if (wr_ok) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_strb[b]) begin
                    shadow_d[wr_addr][b*8 +: 8] = wr_data[b*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        dirty_d = dirty_q;
        if (wr_ok) begin
            dirty_d = 1'b1;
        end else if (copy_now) begin
            dirty_d = 1'b0;
        end
        wr_err_d = wr_en && !wr_ok;
        done_d   = copy_now;
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = '0;
            if (rd_in_range) begin
                rd_data_d = rd_sel ? active_q[rd_addr] : shadow_q[rd_addr];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            start_flag_q <= 1'b0;
            dirty_q      <= 1'b0;
            wr_err_q     <= 1'b0;
            done_q       <= 1'b0;
            rd_data_q    <= '0;
            rd_vld_q     <= 1'b0;
            for (int i = 0; i < CFG_WORD_N; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            start_flag_q <= start_flag_d;
            dirty_q      <= dirty_d;
            wr_err_q     <= wr_err_d;
            done_q       <= done_d;
            rd_data_q    <= rd_data_d;
            rd_vld_q     <= rd_en;
            for (int i = 0; i < CFG_WORD_N; i++) begin
                shadow_q[i] <= shadow_d[i];
                if (copy_now) active_q[i] <= shadow_q[i];
            end
        end
    end

    for (genvar g = 0; g < CFG_WORD_N; g++) begin : g_flat
        assign cfg_active[g*DATA_WIDTH +: DATA_WIDTH] = active_q[g];
    end

    assign wr_err      = wr_err_q;
    assign rd_data     = rd_data_q;
    assign rd_vld      = rd_vld_q;
    assign cfg_dirty   = dirty_q;
    assign commit_done = done_q;
    assign cfg_locked  = (state_q != S_IDLE);
    assign cal_start   = (state_q == S_START);

endmodule

// File: tb/tb_conv_cfg_shadow_regfile.sv
// Directed bench for conv_cfg_shadow_regfile.
// Uses 12 words so that an out-of-range address fits in ADDR_WIDTH.
module tb_conv_cfg_shadow_regfile;

    localparam int N  = 12;
    localparam int DW = 32;
    localparam int AW = 4;

    logic              clk;
    logic              rst_n;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic [DW/8-1:0]   wr_strb;
    logic              wr_err;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic              rd_sel;
    logic [DW-1:0]     rd_data;
    logic              rd_vld;
    logic              commit_req;
    logic              commit_start;
    logic              core_busy;
    logic              cfg_locked;
    logic              cfg_dirty;
    logic              commit_done;
    logic              cal_start;
    logic [N*DW-1:0]   cfg_active;

    int checks;
    int errors;

    conv_cfg_shadow_regfile #(
        .CFG_WORD_N(N),
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_strb(wr_strb),
        .wr_err(wr_err),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .rd_sel(rd_sel),
        .rd_data(rd_data),
        .rd_vld(rd_vld),
        .commit_req(commit_req),
        .commit_start(commit_start),
        .core_busy(core_busy),
        .cfg_locked(cfg_locked),
        .cfg_dirty(cfg_dirty),
        .commit_done(commit_done),
        .cal_start(cal_start),
        .cfg_active(cfg_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] act(input int i);
        return cfg_active[i*DW +: DW];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        wr_en        = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        wr_strb      = '0;
        rd_en        = 1'b0;
        rd_addr      = '0;
        rd_sel       = 1'b0;
        commit_req   = 1'b0;
        commit_start = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [3:0] s);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
        step();
        wr_en = 1'b0; wr_strb = '0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic sel);
        rd_en = 1'b1; rd_addr = a; rd_sel = sel;
        step();
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        core_busy = 1'b0;
        rst_n = 1'b0;
        repeat (3) step();
        checks++;
        if ({wr_err, rd_vld, cfg_locked, cfg_dirty, commit_done, cal_start} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b exp 000000",
                     {wr_err, rd_vld, cfg_locked, cfg_dirty, commit_done, cal_start});
        end
        checks++;
        if (rd_data !== '0 || cfg_active !== '0) begin
            errors++;
            $display("FAIL reset_data got rd_data %h active_or %b exp 0", rd_data, |cfg_active);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_write_strobe();
        do_write(4'd3, 32'hDEADBEEF, 4'hF);
        do_write(4'd3, 32'h00001234, 4'h3);
        checks++;
        if (wr_err !== 1'b0) begin
            errors++; $display("FAIL wr_ok_err got %b exp 0", wr_err);
        end
        do_read(4'd3, 1'b0);
        checks++;
        if (rd_vld !== 1'b1 || rd_data !== 32'hDEAD1234) begin
            errors++;
            $display("FAIL shadow3 got vld %b data %h exp 1 DEAD1234", rd_vld, rd_data);
        end
        do_read(4'd3, 1'b1);
        checks++;
        if (rd_data !== 32'h0) begin
            errors++; $display("FAIL active3_pre got %h exp 0", rd_data);
        end
        checks++;
        if (cfg_dirty !== 1'b1 || act(3) !== 32'h0) begin
            errors++;
            $display("FAIL dirty_pre got dirty %b act3 %h exp 1 0", cfg_dirty, act(3));
        end
    endtask

    task automatic test_commit_start();
        commit_req = 1'b1; commit_start = 1'b1;
        step();
        commit_req = 1'b0; commit_start = 1'b0;
        checks++;
        if (cfg_locked !== 1'b1 || commit_done !== 1'b0 || cal_start !== 1'b0) begin
            errors++;
            $display("FAIL c1_wait got lock %b done %b start %b exp 1 0 0",
                     cfg_locked, commit_done, cal_start);
        end
        step();
        checks++;
        if (cfg_locked !== 1'b1 || act(3) !== 32'h0) begin
            errors++;
            $display("FAIL c2_copy got lock %b act3 %h exp 1 0", cfg_locked, act(3));
        end
        step();
        checks++;
        if (commit_done !== 1'b1 || cal_start !== 1'b1 || cfg_locked !== 1'b1) begin
            errors++;
            $display("FAIL c3_done got done %b start %b lock %b exp 1 1 1",
                     commit_done, cal_start, cfg_locked);
        end
        checks++;
        if (act(3) !== 32'hDEAD1234 || cfg_dirty !== 1'b0) begin
            errors++;
            $display("FAIL c3_active got act3 %h dirty %b exp DEAD1234 0", act(3), cfg_dirty);
        end
        step();
        checks++;
        if (cfg_locked !== 1'b0 || cal_start !== 1'b0 || commit_done !== 1'b0) begin
            errors++;
            $display("FAIL c4_idle got lock %b start %b done %b exp 0 0 0",
                     cfg_locked, cal_start, commit_done);
        end
    endtask

    task automatic test_busy_wait();
        do_write(4'd5, 32'h11111111, 4'hF);
        core_busy = 1'b1;
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        do_write(4'd5, 32'hFFFFFFFF, 4'hF);
        checks++;
        if (wr_err !== 1'b1) begin
            errors++; $display("FAIL busy_wr_err got %b exp 1", wr_err);
        end
        repeat (8) begin
            step();
            checks++;
            if (cfg_locked !== 1'b1 || commit_done !== 1'b0 || act(5) !== 32'h0) begin
                errors++;
                $display("FAIL busy_hold got lock %b done %b act5 %h exp 1 0 0",
                         cfg_locked, commit_done, act(5));
            end
        end
        core_busy = 1'b0;
        step();
        checks++;
        if (commit_done !== 1'b0 || act(5) !== 32'h0) begin
            errors++;
            $display("FAIL busy_copy got done %b act5 %h exp 0 0", commit_done, act(5));
        end
        step();
        checks++;
        if (commit_done !== 1'b1 || cal_start !== 1'b0 || act(5) !== 32'h11111111) begin
            errors++;
            $display("FAIL busy_done got done %b start %b act5 %h exp 1 0 11111111",
                     commit_done, cal_start, act(5));
        end
        do_read(4'd5, 1'b0);
        checks++;
        if (rd_data !== 32'h11111111) begin
            errors++; $display("FAIL busy_shadow5 got %h exp 11111111", rd_data);
        end
    endtask

    task automatic test_out_of_range();
        do_write(4'd12, 32'hAAAAAAAA, 4'hF);
        checks++;
        if (wr_err !== 1'b1 || cfg_dirty !== 1'b0) begin
            errors++;
            $display("FAIL oor_wr got err %b dirty %b exp 1 0", wr_err, cfg_dirty);
        end
        do_read(4'd12, 1'b0);
        checks++;
        if (rd_vld !== 1'b1 || rd_data !== 32'h0 || wr_err !== 1'b0) begin
            errors++;
            $display("FAIL oor_rd got vld %b data %h err %b exp 1 0 0", rd_vld, rd_data, wr_err);
        end
    endtask

    task automatic test_write_with_commit();
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'hCAFEF00D; wr_strb = 4'hF;
        commit_req = 1'b1; commit_start = 1'b0;
        step();
        clear_inputs();
        checks++;
        if (wr_err !== 1'b0 || cfg_locked !== 1'b1 || cfg_dirty !== 1'b1) begin
            errors++;
            $display("FAIL wc_c1 got err %b lock %b dirty %b exp 0 1 1",
                     wr_err, cfg_locked, cfg_dirty);
        end
        step();
        step();
        checks++;
        if (commit_done !== 1'b1 || cal_start !== 1'b0 || act(7) !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL wc_c3 got done %b start %b act7 %h exp 1 0 CAFEF00D",
                     commit_done, cal_start, act(7));
        end
        step();
        checks++;
        if (cal_start !== 1'b0 || cfg_locked !== 1'b0) begin
            errors++;
            $display("FAIL wc_c4 got start %b lock %b exp 0 0", cal_start, cfg_locked);
        end
    endtask

    task automatic test_back_to_back();
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'h55555555; wr_strb = 4'hF;
        rd_en = 1'b1; rd_addr = 4'd3; rd_sel = 1'b0;
        step();
        clear_inputs();
        checks++;
        if (rd_data !== 32'hDEAD1234) begin
            errors++; $display("FAIL rw_same got %h exp DEAD1234", rd_data);
        end
        rd_en = 1'b1; rd_addr = 4'd3; rd_sel = 1'b0;
        step();
        rd_addr = 4'd3; rd_sel = 1'b1;
        checks++;
        if (rd_vld !== 1'b1 || rd_data !== 32'h55555555) begin
            errors++;
            $display("FAIL b2b_0 got vld %b data %h exp 1 55555555", rd_vld, rd_data);
        end
        step();
        rd_addr = 4'd7; rd_sel = 1'b1;
        checks++;
        if (rd_vld !== 1'b1 || rd_data !== 32'hDEAD1234) begin
            errors++;
            $display("FAIL b2b_1 got vld %b data %h exp 1 DEAD1234", rd_vld, rd_data);
        end
        step();
        rd_en = 1'b0;
        checks++;
        if (rd_vld !== 1'b1 || rd_data !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL b2b_2 got vld %b data %h exp 1 CAFEF00D", rd_vld, rd_data);
        end
        step();
        checks++;
        if (rd_vld !== 1'b0) begin
            errors++; $display("FAIL b2b_end got vld %b exp 0", rd_vld);
        end
    endtask

    task automatic test_reset_in_wait();
        core_busy = 1'b1;
        commit_req = 1'b1; commit_start = 1'b1;
        rd_en = 1'b1; rd_addr = 4'd3; rd_sel = 1'b1;
        step();
        clear_inputs();
        checks++;
        if (cfg_locked !== 1'b1 || rd_vld !== 1'b1) begin
            errors++;
            $display("FAIL rw_wait got lock %b vld %b exp 1 1", cfg_locked, rd_vld);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cfg_locked, cfg_dirty, commit_done, cal_start, wr_err, rd_vld} !== 6'b0 ||
            rd_data !== '0 || cfg_active !== '0) begin
            errors++;
            $display("FAIL async_rst got flags %b rd %h active_or %b exp 0",
                     {cfg_locked, cfg_dirty, commit_done, cal_start, wr_err, rd_vld},
                     rd_data, |cfg_active);
        end
        step();
        rst_n = 1'b1;
        core_busy = 1'b0;
        repeat (5) begin
            step();
            checks++;
            if (cfg_locked !== 1'b0 || cal_start !== 1'b0 || commit_done !== 1'b0) begin
                errors++;
                $display("FAIL post_rst got lock %b start %b done %b exp 0 0 0",
                         cfg_locked, cal_start, commit_done);
            end
        end
        do_write(4'd1, 32'h12345678, 4'h0);
        checks++;
        if (cfg_dirty !== 1'b1 || wr_err !== 1'b0) begin
            errors++;
            $display("FAIL zero_strb got dirty %b err %b exp 1 0", cfg_dirty, wr_err);
        end
        do_read(4'd1, 1'b0);
        checks++;
        if (rd_data !== 32'h0) begin
            errors++; $display("FAIL zero_strb_data got %h exp 0", rd_data);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_write_strobe();
        test_commit_start();
        test_busy_wait();
        test_out_of_range();
        test_write_with_commit();
        test_back_to_back();
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
